// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode instruction queue: a circular FIFO of {pc, instr, cf_type}
// entries with a valid/ready handshake on both sides and a single-cycle flush.
module fetch_instr_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [1:0]               out_cf_type,
    output logic [$clog2(DEPTH):0]   count
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high and flush is low; flush drops both the offered pair and the pop.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [1:0]      cf_mem    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occupancy;
    logic          enq;
    logic          deq;

    function automatic logic [1:0] classify(input logic [6:0] opcode);
        case (opcode)
            7'b1100011: classify = 2'b01;
            7'b1101111: classify = 2'b10;
            7'b1100111: classify = 2'b11;
            default:    classify = 2'b00;
        endcase
    endfunction

    assign in_ready  = (occupancy != CW'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;
    assign count     = occupancy;

    // Head is a plain read at rd_ptr; an empty queue never bypasses the input.
    assign out_pc      = pc_mem[rd_ptr];
    assign out_instr   = instr_mem[rd_ptr];
    assign out_cf_type = cf_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      occupancy <= occupancy + 1'b1;
            else if (deq && !enq) occupancy <= occupancy - 1'b1;
        end
    end

    // Storage is deliberately left uncleared by reset and flush.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            cf_mem[wr_ptr]    <= classify(in_instr[6:0]);
        end
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: directed scenarios plus random traffic, checked
// against a queue-based reference of accepted entries.
module tb_fetch_instr_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int EW    = 2 * XLEN + 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   flush = 1'b0;
    logic                   in_valid = 1'b0;
    logic [XLEN-1:0]        in_pc = '0;
    logic [XLEN-1:0]        in_instr = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_instr;
    logic [1:0]             out_cf_type;
    logic [$clog2(DEPTH):0] count;

    logic [EW-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    fetch_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_cf_type(out_cf_type), .count(count)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    function automatic logic [1:0] ref_cf(input logic [XLEN-1:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        if (op == 7'h63) return 2'b01;
        if (op == 7'h6F) return 2'b10;
        if (op == 7'h67) return 2'b11;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a list of accepted entries in arrival order
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            automatic bit pop  = out_ready && (exp_q.size() > 0);
            automatic bit push = in_valid && (exp_q.size() < DEPTH);
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({in_pc, in_instr, ref_cf(in_instr)});
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_pc", 64'(out_pc), 64'(exp_q[0][EW-1 -: XLEN]));
                chk("out_instr", 64'(out_instr), 64'(exp_q[0][XLEN+1 -: XLEN]));
                chk("out_cf_type", 64'(out_cf_type), 64'(exp_q[0][1:0]));
            end
        end
    end

    // driver tasks
    task automatic step(input bit v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                        input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [6:0]      ops [5];
    logic [XLEN-1:0] rnd_pc;
    logic [XLEN-1:0] rnd_instr;
    bit              rnd_v;

    initial begin
        ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h13; ops[4] = 7'h33;

        // reset mid-cycle with no clock edge, then idle
        async_reset();
        mon_en = 1'b1;
        idle(5);

        // fill to DEPTH, one rejected push, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, XLEN'(4 * i), 32'h00000013, 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'h10, 32'h00000013, 1'b0, 1'b0);
        chk("fifth_push_count", 64'(count), 64'(DEPTH));
        drain(DEPTH);
        chk("drained_out_valid", 64'(out_valid), 64'd0);

        // sustained push+pop at occupancy 2, across pointer wrap
        step(1'b1, 32'h100, 32'h00000013, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'h00000013, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, XLEN'(32'h108 + 4 * i), 32'h00100093 + XLEN'(i << 20), 1'b1, 1'b0);
            chk("steady_count", 64'(count), 64'd2);
        end
        drain(2);

        // predecode classes
        step(1'b1, 32'h200, 32'h00C58663, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h0080006F, 1'b0, 1'b0);
        step(1'b1, 32'h208, 32'h000080E7, 1'b0, 1'b0);
        step(1'b1, 32'h20C, 32'h00500093, 1'b0, 1'b0);
        chk("cf_head_beq", 64'(out_cf_type), 64'd1);
        drain(1);
        chk("cf_head_jal", 64'(out_cf_type), 64'd2);
        drain(1);
        chk("cf_head_jalr", 64'(out_cf_type), 64'd3);
        drain(1);
        chk("cf_head_addi", 64'(out_cf_type), 64'd0);
        drain(1);

        // flush with 3 queued, concurrent push and pop both dropped
        for (int i = 0; i < 3; i++) step(1'b1, XLEN'(32'h300 + 4 * i), 32'h00000013, 1'b0, 1'b0);
        step(1'b1, 32'h40, 32'h00000013, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h80, 32'h0000006F, 1'b0, 1'b0);
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_pc", 64'(out_pc), 64'h80);
        drain(1);

        // reset in the middle of traffic
        step(1'b1, 32'h500, 32'h00000013, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h00000013, 1'b0, 1'b0);
        in_valid = 1'b0;
        async_reset();
        idle(2);

        // random traffic; pc/instr held while a push is being back-pressured
        rnd_v = 1'b0;
        rnd_pc = '0;
        rnd_instr = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(rnd_v && exp_q.size() == DEPTH)) begin
                rnd_v = ($urandom_range(0, 3) != 0);
                rnd_pc = $urandom();
                rnd_instr = $urandom();
                rnd_instr[6:0] = ops[$urandom_range(0, 4)];
            end
            step(rnd_v, rnd_pc, rnd_instr, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0));
        end
        drain(DEPTH + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_instr_queue.md
# fetch_instr_queue

Instruction queue between the fetch stage and the decode stage. It captures each {PC, instruction} pair returned by instruction memory and holds it in a small circular FIFO. It presents the oldest entry to decode under a valid/ready handshake and discards all queued entries on a pipeline flush. Each entry carries a predecoded control-transfer class so decode and the hazard logic see branch/jump type without re-decoding.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, PC and instruction width

Ports:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries (taken branch / redirect)
- in_valid  input  1  fetch presents a valid pair this cycle
- in_pc  input  XLEN  PC of the fetched instruction
- in_instr  input  XLEN  instruction word from instruction memory
- in_ready  output  1  queue can accept a pair this cycle
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  XLEN  PC of the head entry
- out_instr  output  XLEN  instruction of the head entry
- out_cf_type  output  2  head class: 00 none, 01 B-type (opcode 1100011), 10 JAL (1101111), 11 JALR (1100111)
- count  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {pc, instr, cf_type}, a write pointer, a read pointer, and an occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue: in_valid && in_ready && !flush writes the entry at wr_ptr and increments wr_ptr. cf_type is computed from in_instr[6:0] at write time. Any other opcode gives 00.
- Dequeue: out_valid && out_ready && !flush increments rd_ptr.
- count: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither occur.
- in_ready = (count != DEPTH). There is no write-through when full, even if a dequeue happens in the same cycle.
- out_valid = (count != 0). out_pc, out_instr and out_cf_type are the combinational read of the entry at rd_ptr. There is no bypass from in_* to out_* when empty.
- While out_valid=0, out_pc, out_instr and out_cf_type are don't-care. The bench must not check them.
- Flush:
  - rd_ptr, wr_ptr and count go to 0 at the next edge.
  - An in_valid or out_ready asserted in the flush cycle has no effect: the pair is dropped and nothing is popped.
  - Entry storage contents are not cleared.
- Back-pressure: fetch must hold in_pc and in_instr stable while in_valid=1 and in_ready=0. The queue does not check this.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by system):
  - rd_ptr=0, wr_ptr=0, count=0
  - out_valid=0, in_ready=1, count output=0
- Reset asserted mid-operation clears the pointers and counter immediately, with no clock edge needed. Queued entries are lost.
- Enqueue-to-output latency: a pair accepted at edge N appears at out_* with out_valid=1 after edge N, when the queue was empty.
- Throughput: one enqueue and one dequeue per cycle sustained at any occupancy 1..DEPTH-1.
- When full, in_ready deasserts in the cycle after the DEPTH-th accept. It reasserts in the cycle after the first dequeue.
- Flush and reset priority: reset > flush > enqueue/dequeue.

## Test plan
- Reset, then idle: assert reset mid-cycle → out_valid=0, in_ready=1, count=0 without a clock edge. Release reset; hold 5 cycles → outputs unchanged.
- Fill and drain, DEPTH=4:
  - With out_ready=0, push PCs 0x00,0x04,0x08,0x0C (instr 0x00000013) → count=4, in_ready=0.
  - A fifth push is ignored.
  - Then out_ready=1 → out_pc sequence 0x00,0x04,0x08,0x0C, out_valid=0 after the fourth pop.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2 and output order is strictly FIFO. Continue across a wrap-around of both pointers.
- Predecode classes: push 0x00C58663 (BEQ), 0x0080006F (JAL), 0x000080E7 (JALR), 0x00500093 (ADDI) → out_cf_type 01,10,11,00 in order.
- Flush with 3 queued entries, while in_valid=1 (pc 0x40) and out_ready=1 → next cycle count=0, out_valid=0, and 0x40 is not enqueued. A push of 0x80 in the following cycle appears at out_pc one cycle later.
